// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package fetch_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_W     = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StWait,
    StFlush
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small {pc, instr} FIFO between fetch and decode. Flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [31:0]       push_instr_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [31:0]       head_instr_o,
  output logic [CntW-1:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [PtrW-1:0]   wr_q, rd_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] pc_mem_q    [Depth];
  logic [31:0]       instr_mem_q [Depth];
  logic              do_push, do_pop;

  // A push at full is legal only together with a pop (slot freed this cycle).
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != DepthCnt) || do_pop);

  // Pointer, count and storage update; Depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        pc_mem_q[wr_q]    <= push_pc_i;
        instr_mem_q[wr_q] <= push_instr_i;
        wr_q              <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign head_pc_o    = pc_mem_q[rd_q];
  assign head_instr_o = instr_mem_q[rd_q];
  assign count_o      = cnt_q;
  assign full_o       = (cnt_q == DepthCnt);
  assign empty_o      = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: toggle-handshake word reads, redirect handling,
// and a small instruction buffer toward decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] memAddrOut,
  output logic        triggerOut,
  input  logic [31:0] memDataIn,
  input  logic        ackIn,
  input  logic        redirectIn,
  input  logic [31:0] redirectPc,
  output logic [31:0] instrOut,
  output logic [31:0] pcOut,
  output logic        validOut,
  input  logic        decodeReadyIn,
  output logic        busyOut
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              trig_q, trig_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              ack_last_q;
  logic              ack_edge;

  logic              push, pop, flush;
  logic [CntW-1:0]   count;
  logic [CntW-1:0]   cnt_after_push;
  logic              full, empty;

  assign ack_edge = sync_q[SYNC_STAGES-1] ^ ack_last_q;

  // Redirect flushes the buffer, so a same-cycle pop is dropped.
  assign pop   = !empty && decodeReadyIn && !redirectIn;
  assign flush = redirectIn;
  assign cnt_after_push = count + CntW'(1) - CntW'(pop);

  // Ack synchronizer plus previous-value register for toggle detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      ack_last_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ackIn};
      ack_last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Next-state, PC, trigger and push decisions.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    trig_d  = trig_q;
    push    = 1'b0;
    if (redirectIn) begin
      pc_d = redirectPc & 32'hFFFF_FFFC;
      case (state_q)
        // An ack landing with the redirect consumes the outstanding request.
        StWait, StFlush: state_d = ack_edge ? StSetup : StFlush;
        default:         state_d = StSetup;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!full) state_d = StSetup;
        end
        StSetup: begin
          trig_d  = ~trig_q;
          state_d = StWait;
        end
        StWait: begin
          if (ack_edge) begin
            push    = 1'b1;
            pc_d    = pc_q + ADDR_W'(WORD_BYTES);
            state_d = (cnt_after_push < DepthCnt) ? StSetup : StIdle;
          end
        end
        StFlush: begin
          if (ack_edge) state_d = StSetup;
        end
      endcase
    end
  end

  // Address is loaded only on entry to SETUP and held through WAIT/FLUSH.
  always_comb begin
    addr_d = addr_q;
    if (state_d == StSetup) addr_d = {2'b00, pc_d[ADDR_W-1:2]};
  end

  // FSM and request-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      addr_q  <= {2'b00, RESET_PC[31:2]};
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      trig_q  <= trig_d;
    end
  end

  fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_pc_i    (pc_q),
    .push_instr_i (memDataIn),
    .pop_i        (pop),
    .flush_i      (flush),
    .head_pc_o    (pcOut),
    .head_instr_o (instrOut),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  assign memAddrOut = addr_q;
  assign triggerOut = trig_q;
  assign validOut   = !empty;
  assign busyOut    = (state_q == StWait) || (state_q == StFlush);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a toggle-handshake memory responder
// and a scoreboard of expected {pc, instr} deliveries.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] memAddrOut;
  logic        triggerOut;
  logic [31:0] memDataIn;
  logic        ackIn;
  logic        redirectIn;
  logic [31:0] redirectPc;
  logic [31:0] instrOut;
  logic [31:0] pcOut;
  logic        validOut;
  logic        decodeReadyIn;
  logic        busyOut;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .FIFO_DEPTH  (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .memAddrOut    (memAddrOut),
    .triggerOut    (triggerOut),
    .memDataIn     (memDataIn),
    .ackIn         (ackIn),
    .redirectIn    (redirectIn),
    .redirectPc    (redirectPc),
    .instrOut      (instrOut),
    .pcOut         (pcOut),
    .validOut      (validOut),
    .decodeReadyIn (decodeReadyIn),
    .busyOut       (busyOut)
  );

  // Responder: mem[a] = a + 0x100, acknowledged 3 cycles after seeing a trigger toggle.
  logic        rsp_last_trig;
  logic [31:0] rsp_addr;
  int          rsp_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ackIn         <= 1'b0;
      memDataIn     <= '0;
      rsp_last_trig <= 1'b0;
      rsp_addr      <= '0;
      rsp_cnt       <= 0;
    end else if (triggerOut != rsp_last_trig) begin
      rsp_last_trig <= triggerOut;
      rsp_addr      <= memAddrOut;
      rsp_cnt       <= 3;
    end else if (rsp_cnt > 0) begin
      if (rsp_cnt == 1) begin
        memDataIn <= rsp_addr + 32'h100;
        ackIn     <= ~ackIn;
      end
      rsp_cnt <= rsp_cnt - 1;
    end
  end

  // Scoreboard: every accepted head must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && validOut && decodeReadyIn && !redirectIn) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: pc=%h instr=%h delivered, none expected", pcOut, instrOut);
      end else begin
        e = exp_q.pop_front();
        if (pcOut !== e.pc || instrOut !== e.instr) begin
          failures++;
          $display("FAIL sb_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                   pcOut, instrOut, e.pc, e.instr);
        end
      end
    end
  end

  task automatic expect_word(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    decodeReadyIn = 1'b0;
    redirectIn    = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Accept decode output until all expectations are consumed or the budget runs out.
  task automatic drain(input int budget);
    int n;
    n = 0;
    decodeReadyIn = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    decodeReadyIn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    decodeReadyIn = 1'b0;
    redirectIn = 1'b0;
    redirectPc = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (memAddrOut !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", memAddrOut); end
    if (triggerOut !== 1'b0) begin failures++; $display("FAIL rst_trig: got %b want 0", triggerOut); end
    if (validOut !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", validOut); end
    if (instrOut !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h want 0", instrOut); end
    if (pcOut !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 0", pcOut); end
    if (busyOut !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busyOut); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (triggerOut !== 1'b0) begin failures++; $display("FAIL trig_early: got %b want 0", triggerOut); end
    @(posedge clk);
    #1;
    checks += 2;
    if (triggerOut !== 1'b1) begin failures++; $display("FAIL trig_first: got %b want 1", triggerOut); end
    if (busyOut !== 1'b1) begin failures++; $display("FAIL busy_wait: got %b want 1", busyOut); end
  endtask

  task automatic test_backpressure();
    int   toggles;
    logic prev;
    toggles = 0;
    prev    = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (triggerOut !== prev) toggles++;
      prev = triggerOut;
    end
    checks += 5;
    if (toggles != 2) begin failures++; $display("FAIL bp_toggles: got %0d want 2", toggles); end
    if (busyOut !== 1'b0) begin failures++; $display("FAIL bp_busy: got %b want 0", busyOut); end
    if (validOut !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b want 1", validOut); end
    if (memAddrOut !== 32'h1) begin failures++; $display("FAIL bp_addr: got %h want 1", memAddrOut); end
    if (instrOut !== 32'h100) begin failures++; $display("FAIL bp_head: got %h want 100", instrOut); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) expect_word(32'(i * 4), 32'h100 + 32'(i));
    drain(400);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL stream_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_wait();
    int n;
    apply_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    redirectPc = 32'h0000_1003;
    redirectIn = 1'b1;
    @(posedge clk);
    #1;
    redirectIn = 1'b0;
    checks += 3;
    if (busyOut !== 1'b1) begin failures++; $display("FAIL rw_flush_busy: got %b want 1", busyOut); end
    if (validOut !== 1'b0) begin failures++; $display("FAIL rw_valid: got %b want 0", validOut); end
    if (memAddrOut !== 32'h0) begin failures++; $display("FAIL rw_addr_held: got %h want 0", memAddrOut); end
    n = 0;
    while (busyOut && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks += 2;
    if (busyOut !== 1'b0) begin failures++; $display("FAIL rw_timeout: busy %b want 0", busyOut); end
    if (memAddrOut !== 32'h400) begin failures++; $display("FAIL rw_addr: got %h want 400", memAddrOut); end
    expect_word(32'h1000, 32'h500);
    expect_word(32'h1004, 32'h501);
    drain(400);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rw_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_ack();
    int   n;
    logic prev;
    apply_reset();
    prev = ackIn;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ackIn === prev && n < 50);
    checks++;
    if (ackIn === prev) begin failures++; $display("FAIL ra_ack_timeout: ack %b unchanged", ackIn); end
    // The toggle lands on the DUT's ack-edge two more edges later; redirect in that cycle.
    @(posedge clk);
    @(posedge clk);
    #1;
    redirectPc = 32'h0000_3000;
    redirectIn = 1'b1;
    @(posedge clk);
    #1;
    redirectIn = 1'b0;
    checks += 3;
    if (busyOut !== 1'b0) begin failures++; $display("FAIL ra_busy: got %b want 0", busyOut); end
    if (memAddrOut !== 32'hC00) begin failures++; $display("FAIL ra_addr: got %h want c00", memAddrOut); end
    if (validOut !== 1'b0) begin failures++; $display("FAIL ra_valid: got %b want 0", validOut); end
    expect_word(32'h3000, 32'hD00);
    expect_word(32'h3004, 32'hD01);
    drain(400);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL ra_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    apply_reset();
    n = 0;
    while (!(busyOut && memAddrOut == 32'h1) && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!(busyOut && memAddrOut == 32'h1)) begin
      failures++;
      $display("FAIL rm_reach: busy=%b addr=%h want 1/1", busyOut, memAddrOut);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (memAddrOut !== 32'h0) begin failures++; $display("FAIL rm_addr: got %h want 0", memAddrOut); end
    if (triggerOut !== 1'b0) begin failures++; $display("FAIL rm_trig: got %b want 0", triggerOut); end
    if (busyOut !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b want 0", busyOut); end
    if (validOut !== 1'b0) begin failures++; $display("FAIL rm_valid: got %b want 0", validOut); end
    if (pcOut !== 32'h0) begin failures++; $display("FAIL rm_pc: got %h want 0", pcOut); end
    if (instrOut !== 32'h0) begin failures++; $display("FAIL rm_instr: got %h want 0", instrOut); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_word(32'h0, 32'h100);
    expect_word(32'h4, 32'h101);
    drain(400);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rm_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    apply_reset();
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (validOut !== 1'b1) begin failures++; $display("FAIL wr_full: valid %b want 1", validOut); end
    redirectPc = 32'hFFFF_FFFC;
    redirectIn = 1'b1;
    @(posedge clk);
    #1;
    redirectIn = 1'b0;
    checks += 2;
    if (validOut !== 1'b0) begin failures++; $display("FAIL wr_flush: valid %b want 0", validOut); end
    if (memAddrOut !== 32'h3FFF_FFFF) begin
      failures++;
      $display("FAIL wr_addr: got %h want 3fffffff", memAddrOut);
    end
    expect_word(32'hFFFF_FFFC, 32'h4000_00FF);
    expect_word(32'h0000_0000, 32'h0000_0100);
    drain(400);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL wr_drain: %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    decodeReadyIn = 1'b0;
    redirectIn    = 1'b0;
    redirectPc    = '0;
    test_reset();
    test_backpressure();
    test_stream();
    test_redirect_wait();
    test_redirect_ack();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch initiator on the core side of the two-phase fetch handshake. Holds the PC and issues word reads to instruction memory by toggling a trigger line. It waits for the memory's toggled acknowledge, then buffers returned instructions in a small FIFO toward decode. Handles branch redirects, including discarding a response already in flight.

## Interface
- `RESET_PC`, 32'h0000_0000: byte PC loaded on reset.
- `FIFO_DEPTH`, 2: instruction buffer entries (power of two, ≥2).
- `SYNC_STAGES`, 2: flops on `ackIn` synchronizer (≥2).

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `memAddrOut` out 32: word address to memory (= PC >> 2).
- `triggerOut` out 1: request line; one toggle = one read request.
- `memDataIn` in 32: read data; stable from responder's ack toggle until next trigger toggle.
- `ackIn` in 1: completion line; one toggle = data valid; asynchronous to `clk`.
- `redirectIn` in 1: branch redirect strobe, one cycle.
- `redirectPc` in 32: new byte PC; bits [1:0] ignored (forced 0).
- `instrOut` out 32: FIFO head instruction.
- `pcOut` out 32: byte PC of `instrOut`.
- `validOut` out 1: FIFO non-empty.
- `decodeReadyIn` in 1: decode accepts head when `validOut && decodeReadyIn`.
- `busyOut` out 1: a request is outstanding (WAIT or FLUSH).

## Operation
- Reset values:
  - PC = `RESET_PC`, `memAddrOut` = `RESET_PC`>>2.
  - `triggerOut` = 0, synchronizer flops and last-ack register = 0.
  - FIFO empty, `validOut` = 0, `instrOut`/`pcOut` = 0, `busyOut` = 0, state IDLE.
- Ack detection: `ackEdge` = sync output XOR registered previous sync output. Both reset to 0, so the responder must be reset with its ack low.
- States:
  - IDLE: if FIFO count < `FIFO_DEPTH` → SETUP.
  - SETUP: drive `memAddrOut` = PC>>2 for one full cycle. Next cycle toggle `triggerOut` → WAIT.
  - WAIT: on `ackEdge` push {PC, `memDataIn`}, PC += 4. Then → SETUP if space remains after push (counting same-cycle pop), else → IDLE.
  - FLUSH: on `ackEdge` discard data → SETUP.
- `memAddrOut` changes only in SETUP; it is held through WAIT/FLUSH.
- Redirect, any state:
  - PC ← {`redirectPc`[31:2],2'b00}; FIFO flushed the same cycle (`validOut` 0 next cycle).
  - From WAIT or FLUSH → FLUSH (the outstanding response is discarded).
  - From IDLE or SETUP → SETUP; a SETUP-cycle toggle is suppressed and the new address is set up first.
- Redirect and `ackEdge` in the same cycle: data discarded, no push, → SETUP with new PC.
- Redirect and pop in the same cycle: pop ignored; flush wins.
- FIFO push and pop in the same cycle: count unchanged; allowed at full because a request is issued only with a free slot reserved.
- At most one request outstanding.
- PC wraps 32'hFFFF_FFFC → 0 silently.
- Reset mid-request: all state returns to reset values immediately. The outstanding response is lost; the responder must be reset together.

## Timing
- Request: addr valid at edge N (enter SETUP), `triggerOut` toggles at edge N+1.
- Ack toggle → `ackEdge` asserted `SYNC_STAGES`+1 edges later; data captured that edge.
- Push → `validOut` high the following cycle.
- Back-to-back fetch period = 2 + sync latency + responder delay.
- Pop: head advances the edge after `validOut && decodeReadyIn`.

## Structure
- `fetch_pkg`: state enum {IDLE, SETUP, WAIT, FLUSH}, `WORD_BYTES` = 4, `ADDR_W` = 32.
- Sub-module `fetch_fifo`: parameterised {pc, instr} FIFO with push, pop, flush, count, full, empty; flush has priority over push and pop.
- Synchronizer and FSM live inline in `fetch_unit`.

## Test plan
- Reset release, responder acks each toggle after 3 cycles with mem[a] = a+0x100 → `pcOut`/`instrOut` = 0/0x100, 4/0x101, 8/0x102 in order; `triggerOut` first toggles 2 cycles after reset release.
- `decodeReadyIn` held 0 → exactly `FIFO_DEPTH` toggles, then IDLE with no further toggles. Raise `decodeReadyIn` → fetch resumes at PC 8.
- Redirect to 0x1003 while in WAIT → late ack data dropped, next `memAddrOut` = 0x400, first `pcOut` = 0x1000.
- Redirect in the same cycle as `ackEdge` → no push; next request at the redirect address.
- Assert `rst_n` low during WAIT → all outputs at reset values; after release the first request is at `RESET_PC`.
- PC 0xFFFF_FFFC fetch → next `memAddrOut` = 0, `pcOut` = 0.
